frontend_ctrl: RTL and testbench

//  Sequencer for the frontend pipeline (fetch -> decode -> rename) and its 1-cycle imem port.

---
 rtl/frontend_ctrl_pkg.sv | 29 ++
 rtl/frontend_ctrl_if.sv | 61 ++++++
 rtl/frontend_ctrl_arb.sv | 57 +++++
 rtl/frontend_ctrl.sv | 135 +++++++++++++
 tb/tb_frontend_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frontend_ctrl_pkg.sv
// ============================================================================
// Package : frontend_pkg
// Brief   : Shared types and defaults for the frontend sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package frontend_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int MAX_OUT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    REDIR = 3'd3,
    HALT  = 3'd4
  } fe_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    EXC  = 2'd2
  } redir_src_t;

endpackage

`default_nettype wire

// File: rtl/frontend_ctrl_if.sv
// ============================================================================
// Interface : frontend_ctrl_if
// Brief     : Requester / pipeline / imem signals of the frontend sequencer.
//             Optional perf counters appear when FRONTEND_PERF_EN is defined.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface frontend_ctrl_if
  import frontend_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic            halt_req;
  logic            exc_valid;
  logic [XLEN-1:0] exc_pc;
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic            decode_ready;
  logic            rename_ready;
  logic            imem_ren;
  logic            imem_valid;
  logic            fetch_en;
  logic            stall;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            resp_drop;
  logic            redir_busy;
  logic [2:0]      state_o;
`ifdef FRONTEND_PERF_EN
  logic [31:0]     perf_stall_cyc;
  logic [31:0]     perf_redirects;
`endif

  // Controller side
  modport slave (
    input  start, halt_req, exc_valid, exc_pc, br_valid, br_pc,
    input  decode_ready, rename_ready, imem_ren, imem_valid,
    output fetch_en, stall, redirect_en, redirect_pc, flush,
    output resp_drop, redir_busy, state_o
`ifdef FRONTEND_PERF_EN
    , output perf_stall_cyc, perf_redirects
`endif
  );

  // Environment side
  modport master (
    output start, halt_req, exc_valid, exc_pc, br_valid, br_pc,
    output decode_ready, rename_ready, imem_ren, imem_valid,
    input  fetch_en, stall, redirect_en, redirect_pc, flush,
    input  resp_drop, redir_busy, state_o
`ifdef FRONTEND_PERF_EN
    , input perf_stall_cyc, perf_redirects
`endif
  );

endinterface

`default_nettype wire

// File: rtl/frontend_ctrl_arb.sv
// ============================================================================
// Module : fe_redirect_arb
// Brief  : Pending-redirect register. Exception beats branch on capture; a
//          later exception replaces a pending branch while draining; a later
//          branch never replaces anything.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fe_redirect_arb
  import frontend_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  wire            clk,
  input  wire            reset_n,
  input  wire            i_cap_en,
  input  wire            i_drain_en,
  input  wire            i_clr,
  input  wire            i_exc_valid,
  input  wire [XLEN-1:0] i_exc_pc,
  input  wire            i_br_valid,
  input  wire [XLEN-1:0] i_br_pc,
  output logic           o_pend_valid,
  output logic [XLEN-1:0] o_pend_pc
);

  redir_src_t      r_src;
  logic [XLEN-1:0] r_pc;

  // Capture, overwrite or retire the pending redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src <= NONE;
      r_pc  <= '0;
    end else if (i_clr) begin
      r_src <= NONE;
    end else if (i_cap_en) begin
      if (i_exc_valid) begin
        r_src <= EXC;
        r_pc  <= i_exc_pc;
      end else if (i_br_valid) begin
        r_src <= BR;
        r_pc  <= i_br_pc;
      end
    end else if (i_drain_en && i_exc_valid && (r_src == BR)) begin
      r_src <= EXC;
      r_pc  <= i_exc_pc;
    end
  end

  assign o_pend_valid = (r_src != NONE);
  assign o_pend_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/frontend_ctrl.sv
// ============================================================================
// Module : frontend_ctrl
// Brief  : Frontend sequencer: fetch enable / stall, outstanding imem request
//          tracking, redirect flush-drain-redirect sequencing.
//          Define FRONTEND_PERF_EN to add stall-cycle and redirect counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frontend_ctrl
  import frontend_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input wire             clk,
  input wire             reset_n,
  frontend_ctrl_if.slave bus
);

  localparam int            CW        = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] C_MAX_OUT = CW'(MAX_OUT);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  fe_state_t       r_state;
  fe_state_t       w_next;
  logic [CW-1:0]   r_outs;
  logic            r_flush;
  logic            w_req;
  logic            w_stall;
  logic            w_pend_valid;
  logic [XLEN-1:0] w_pend_pc;

  assign w_req = bus.exc_valid | bus.br_valid;

  fe_redirect_arb #(.XLEN(XLEN)) u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_cap_en     ((r_state == RUN) || (r_state == HALT)),
    .i_drain_en   (r_state == DRAIN),
    .i_clr        (r_state == REDIR),
    .i_exc_valid  (bus.exc_valid),
    .i_exc_pc     (bus.exc_pc),
    .i_br_valid   (bus.br_valid),
    .i_br_pc      (bus.br_pc),
    .o_pend_valid (w_pend_valid),
    .o_pend_pc    (w_pend_pc)
  );

  // Outstanding imem request count; simultaneous issue and return cancel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outs <= '0;
    end else if (bus.imem_ren && !bus.imem_valid) begin
      if (r_outs != C_MAX_OUT) r_outs <= r_outs + C_ONE;
    end else if (bus.imem_valid && !bus.imem_ren) begin
      if (r_outs != '0) r_outs <= r_outs - C_ONE;
    end
  end

  // State register plus a flag marking the first DRAIN cycle (flush pulse)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= (w_next == DRAIN) && (r_state != DRAIN);
    end
  end

  // Next-state: redirects outrank halt/start; DRAIN waits for the last response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.start) w_next = RUN;
      RUN: begin
        if (w_req)             w_next = DRAIN;
        else if (bus.halt_req) w_next = HALT;
      end
      HALT: begin
        if (w_req)                            w_next = DRAIN;
        else if (bus.start && !bus.halt_req)  w_next = RUN;
      end
      DRAIN: begin
        if ((r_outs == '0) || ((r_outs == C_ONE) && bus.imem_valid))
          w_next = REDIR;
      end
      REDIR: w_next = bus.halt_req ? HALT : RUN;
      default: w_next = IDLE;
    endcase
  end

  assign w_stall = (r_state == RUN) &&
                   (!bus.decode_ready || !bus.rename_ready || (r_outs == C_MAX_OUT));

  assign bus.fetch_en    = (r_state == RUN);
  assign bus.stall       = w_stall;
  assign bus.redirect_en = (r_state == REDIR);
  assign bus.redirect_pc = (r_state == REDIR) ? w_pend_pc : '0;
  assign bus.flush       = r_flush;
  assign bus.resp_drop   = (r_state == DRAIN) && bus.imem_valid;
  assign bus.redir_busy  = (r_state == DRAIN) || (r_state == REDIR);
  assign bus.state_o     = r_state;

`ifdef FRONTEND_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  // Free-running, wrapping performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_stall)            r_perf_stall <= r_perf_stall + 32'd1;
      if (r_state == REDIR)   r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign bus.perf_stall_cyc = r_perf_stall;
  assign bus.perf_redirects = r_perf_redir;
`endif

  // Protocol checks: no issue beyond the outstanding limit; REDIR always has a target
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.imem_ren && (r_outs == C_MAX_OUT)));
      assert (!((r_state == REDIR) && !w_pend_valid));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frontend_ctrl.sv
// ============================================================================
// Module : tb_frontend_ctrl
// Brief  : Self-checking bench for frontend_ctrl: directed vector tables,
//          an asynchronous reset in DRAIN, and random traffic against a
//          behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_frontend_ctrl;
  import frontend_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  frontend_ctrl_if #(.XLEN(32)) bus ();

  frontend_ctrl #(.XLEN(32), .MAX_OUT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, halt, exc;
    logic [31:0] excpc;
    logic        br;
    logic [31:0] brpc;
    logic        dr, rr, ren, vld;
    logic        fe, stl, rde;
    logic [31:0] rpc;
    logic        fl, drop, busy;
    logic [2:0]  state;
  } vec_t;

  function automatic vec_t mk(logic start, logic halt, logic exc, logic [31:0] excpc,
                              logic br, logic [31:0] brpc, logic dr, logic rr,
                              logic ren, logic vld, logic fe, logic stl, logic rde,
                              logic [31:0] rpc, logic fl, logic drop, logic busy,
                              logic [2:0] state);
    vec_t v;
    v.start = start; v.halt = halt; v.exc = exc; v.excpc = excpc;
    v.br = br; v.brpc = brpc; v.dr = dr; v.rr = rr; v.ren = ren; v.vld = vld;
    v.fe = fe; v.stl = stl; v.rde = rde; v.rpc = rpc; v.fl = fl;
    v.drop = drop; v.busy = busy; v.state = state;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.start = v.start; bus.halt_req = v.halt;
    bus.exc_valid = v.exc; bus.exc_pc = v.excpc;
    bus.br_valid = v.br; bus.br_pc = v.brpc;
    bus.decode_ready = v.dr; bus.rename_ready = v.rr;
    bus.imem_ren = v.ren; bus.imem_valid = v.vld;
  endtask

  task automatic check_outs(string tag, vec_t v);
    chk({tag, ".fetch_en"},    32'(bus.fetch_en),    32'(v.fe));
    chk({tag, ".stall"},       32'(bus.stall),       32'(v.stl));
    chk({tag, ".redirect_en"}, 32'(bus.redirect_en), 32'(v.rde));
    chk({tag, ".redirect_pc"}, bus.redirect_pc,      v.rpc);
    chk({tag, ".flush"},       32'(bus.flush),       32'(v.fl));
    chk({tag, ".resp_drop"},   32'(bus.resp_drop),   32'(v.drop));
    chk({tag, ".redir_busy"},  32'(bus.redir_busy),  32'(v.busy));
    chk({tag, ".state_o"},     32'(bus.state_o),     32'(v.state));
  endtask

  // One clock cycle: inputs already after posedge, check at negedge
  task automatic apply(string tag, vec_t v);
    drive(v);
    @(negedge clk);
    check_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state (random phase)
  int          m_st;      // 0 idle,1 run,2 drain,3 redir,4 halt
  int          m_outs;
  int          m_kind;    // 0 none,1 branch,2 exception
  logic [31:0] m_pc;
  int          m_dcnt;    // cycles already spent in DRAIN
  logic [31:0] m_pstall, m_predir;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    vec_t tbl2[$];
    vec_t z;
    z = mk(0,0,0,0, 0,0, 1,1, 0,0, 0,0,0,0, 0,0,0, 3'd0);

    //          st hl ex expc   br brpc  dr rr rn vl | fe sl rd rpc    fl dp bz state
    tbl.push_back(mk(1,0,0,0,     0,0,     1,1,0,0, 0,0,0,0,     0,0,0,3'd0)); // 0
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 1
    tbl.push_back(mk(0,0,0,0,     0,0,     1,0,0,0, 1,1,0,0,     0,0,0,3'd1)); // 2
    tbl.push_back(mk(0,0,0,0,     0,0,     1,0,0,0, 1,1,0,0,     0,0,0,3'd1)); // 3
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 4
    tbl.push_back(mk(0,0,0,0,     1,'h40,  1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 5
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,1, 0,0,0,0,     1,1,1,3'd2)); // 6
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 0,0,1,'h40,  0,0,1,3'd3)); // 7
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 8
    tbl.push_back(mk(0,0,1,'h100, 1,'h40,  1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 9
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 0,0,0,0,     1,0,1,3'd2)); // 10
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,1, 0,0,0,0,     0,1,1,3'd2)); // 11
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 0,0,1,'h100, 0,0,1,3'd3)); // 12
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 13
    tbl.push_back(mk(0,0,0,0,     1,'h40,  1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 14
    tbl.push_back(mk(0,0,1,'h200, 0,0,     1,1,0,0, 0,0,0,0,     1,0,1,3'd2)); // 15
    tbl.push_back(mk(0,0,0,0,     1,'h80,  1,1,0,0, 0,0,0,0,     0,0,1,3'd2)); // 16
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,1, 0,0,0,0,     0,1,1,3'd2)); // 17
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 0,0,1,'h200, 0,0,1,3'd3)); // 18
    tbl.push_back(mk(0,0,0,0,     1,'h44,  1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 19
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,0,0,     1,0,1,3'd2)); // 20
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,1,'h44,  0,0,1,3'd3)); // 21
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,0,0,     0,0,0,3'd4)); // 22
    tbl.push_back(mk(1,0,0,0,     0,0,     1,1,0,0, 0,0,0,0,     0,0,0,3'd4)); // 23
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 24
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 25
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 26
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 1,1,0,0,     0,0,0,3'd1)); // 27
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,1, 1,1,0,0,     0,0,0,3'd1)); // 28
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,1, 1,0,0,0,     0,0,0,3'd1)); // 29
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 30
    tbl.push_back(mk(0,1,0,0,     1,'h88,  1,1,0,0, 0,0,0,0,     0,0,0,3'd4)); // 31
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,0,0,     1,0,1,3'd2)); // 32
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,1,'h88,  0,0,1,3'd3)); // 33
    tbl.push_back(mk(0,1,0,0,     0,0,     1,1,0,0, 0,0,0,0,     0,0,0,3'd4)); // 34
    tbl.push_back(mk(1,0,0,0,     0,0,     1,1,0,0, 0,0,0,0,     0,0,0,3'd4)); // 35
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,1,0, 1,0,0,0,     0,0,0,3'd1)); // 36
    tbl.push_back(mk(0,0,0,0,     1,'h40,  1,1,0,0, 1,0,0,0,     0,0,0,3'd1)); // 37
    tbl.push_back(mk(0,0,0,0,     0,0,     1,1,0,0, 0,0,0,0,     1,0,1,3'd2)); // 38

    // After reset in DRAIN: idle ignores redirects; outstanding count restarts at 0
    tbl2.push_back(mk(0,0,1,'h300, 1,'h40, 1,1,0,0, 0,0,0,0, 0,0,0,3'd0));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,0,0, 0,0,0,0, 0,0,0,3'd0));
    tbl2.push_back(mk(1,0,0,0,     0,0,    1,1,0,0, 0,0,0,0, 0,0,0,3'd0));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,1,0, 1,0,0,0, 0,0,0,3'd1));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,1,0, 1,0,0,0, 0,0,0,3'd1));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,0,0, 1,1,0,0, 0,0,0,3'd1));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,0,1, 1,1,0,0, 0,0,0,3'd1));
    tbl2.push_back(mk(0,0,0,0,     0,0,    1,1,0,1, 1,0,0,0, 0,0,0,3'd1));

    // Reset held three cycles
    reset_n = 1'b0;
    drive(z);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("reset%0d", i), z);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset while draining with a pending redirect
    drive(z);
    #2 reset_n = 1'b0;
    #1 check_outs("rst_in_drain", z);
    @(negedge clk);
    check_outs("rst_hold", z);
    @(posedge clk);
    #1 reset_n = 1'b1;
`ifdef FRONTEND_PERF_EN
    chk("perf_redirects_after_reset", bus.perf_redirects, 32'd0);
`endif
    for (int i = 0; i < tbl2.size(); i++) apply($sformatf("post_rst%0d", i), tbl2[i]);

    // Random traffic against the behavioural model
    begin
      bit hl;
      logic fe_e, stl_e, rde_e, fl_e, dp_e, bz_e;
      logic [31:0] rpc_e;
      int nst;
      reset_n = 1'b0;
      drive(z);
      @(posedge clk);
      #1 reset_n = 1'b1;
      m_st = 0; m_outs = 0; m_kind = 0; m_pc = 0; m_dcnt = 0;
      m_pstall = 0; m_predir = 0;
      hl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(19) == 0) hl = ~hl;
        bus.start        = ($urandom_range(7) == 0);
        bus.halt_req     = hl;
        bus.exc_valid    = ($urandom_range(15) == 0);
        bus.exc_pc       = $urandom & 32'hFFFF_FFFC;
        bus.br_valid     = ($urandom_range(7) == 0);
        bus.br_pc        = $urandom & 32'hFFFF_FFFC;
        bus.decode_ready = ($urandom_range(3) != 0);
        bus.rename_ready = ($urandom_range(3) != 0);
        bus.imem_ren     = (m_st == 1) && (m_outs < 2) && ($urandom_range(1) == 1);
        bus.imem_valid   = (m_outs > 0) && ($urandom_range(2) == 0);

        fe_e  = (m_st == 1);
        stl_e = fe_e && (!bus.decode_ready || !bus.rename_ready || m_outs == 2);
        rde_e = (m_st == 3);
        rpc_e = rde_e ? m_pc : 32'd0;
        fl_e  = (m_st == 2) && (m_dcnt == 0);
        dp_e  = (m_st == 2) && bus.imem_valid;
        bz_e  = (m_st == 2) || (m_st == 3);

        @(negedge clk);
        chk("rnd.fetch_en",    32'(bus.fetch_en),    32'(fe_e));
        chk("rnd.stall",       32'(bus.stall),       32'(stl_e));
        chk("rnd.redirect_en", 32'(bus.redirect_en), 32'(rde_e));
        chk("rnd.redirect_pc", bus.redirect_pc,      rpc_e);
        chk("rnd.flush",       32'(bus.flush),       32'(fl_e));
        chk("rnd.resp_drop",   32'(bus.resp_drop),   32'(dp_e));
        chk("rnd.redir_busy",  32'(bus.redir_busy),  32'(bz_e));
        chk("rnd.state_o",     32'(bus.state_o),     32'(m_st));
`ifdef FRONTEND_PERF_EN
        chk("rnd.perf_stall_cyc", bus.perf_stall_cyc, m_pstall);
        chk("rnd.perf_redirects", bus.perf_redirects, m_predir);
`endif
        // Advance the model by one cycle
        nst = m_st;
        case (m_st)
          0: if (bus.start) nst = 1;
          1, 4: begin
            if (bus.exc_valid || bus.br_valid) begin
              m_kind = bus.exc_valid ? 2 : 1;
              m_pc   = bus.exc_valid ? bus.exc_pc : bus.br_pc;
              m_dcnt = 0;
              nst    = 2;
            end else if (m_st == 1 && hl) nst = 4;
            else if (m_st == 4 && bus.start && !hl) nst = 1;
          end
          2: begin
            if (bus.exc_valid && m_kind == 1) begin
              m_kind = 2;
              m_pc   = bus.exc_pc;
            end
            if (m_outs == 0 || (m_outs == 1 && bus.imem_valid)) nst = 3;
            m_dcnt++;
          end
          3: begin
            m_kind = 0;
            m_predir = m_predir + 32'd1;
            nst = hl ? 4 : 1;
          end
          default: nst = 0;
        endcase
        if (stl_e) m_pstall = m_pstall + 32'd1;
        m_outs = m_outs + int'(bus.imem_ren) - int'(bus.imem_valid);
        if (m_outs < 0) m_outs = 0;
        if (m_outs > 2) m_outs = 2;
        m_st = nst;
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
